wptr_full_ctrl: RTL

WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

---
 rtl/wptr_full_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and full-flag controller for an asynchronous FIFO.
// Keeps a binary write pointer and its Gray image for the read domain. It
// raises wfull on the edge that accepts the write into the last free entry.
// It also keeps a sticky overflow flag and, when built with WPTR_LEVEL_EN, a
// registered fill level and almost-full flag.
//
// Parameters:
//   ADDR_SIZE    - FIFO address width, depth = 2**ADDR_SIZE (2..15)
//   AFULL_THRESH - fill level at or above which walmost_full asserts
// Optional feature macro: WPTR_LEVEL_EN (enables wlevel / walmost_full;
//   when undefined both are tied to 0).
//
// Ports:
//   wclk         in   write clock (rising edge)
//   wrst         in   asynchronous active-high reset
//   winc         in   write request
//   wclr_ovf     in   clear request for wovf
//   wq2_rptr     in   Gray read pointer already synchronised to wclk
//   wen          out  memory write enable (combinational: winc & ~wfull)
//   waddr        out  memory write address
//   wptr         out  registered Gray write pointer
//   wfull        out  registered full flag
//   walmost_full out  registered almost-full flag
//   wlevel       out  registered fill level 0..2**ADDR_SIZE
//   wovf         out  sticky overflow flag
module wptr_full_ctrl #(
  parameter int unsigned ADDR_SIZE    = 4,
  parameter int unsigned AFULL_THRESH = 14
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 winc,
  input  logic                 wclr_ovf,
  input  logic [ADDR_SIZE:0]   wq2_rptr,
  output logic                 wen,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [ADDR_SIZE:0]   wptr,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [ADDR_SIZE:0]   wlevel,
  output logic                 wovf
);

  localparam int unsigned AW = ADDR_SIZE;
  localparam int unsigned PW = ADDR_SIZE + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rptr_full_cmp;
  logic          wfull_val;

  // Writes are blocked while full; a rejected write leaves the pointer alone.
  assign wen   = winc & ~wfull;
  assign waddr = wbin[AW-1:0];

  assign wbin_next  = wbin + PW'(wen);
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;

  // Full when the next write pointer equals the read pointer with the two
  // MSBs inverted (one lap ahead, in Gray code).
  assign rptr_full_cmp = {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]};
  assign wfull_val     = (wgray_next == rptr_full_cmp);

  // Pointer, full flag and sticky overflow; a set wins over a clear.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin  <= '0;
      wptr  <= '0;
      wfull <= 1'b0;
      wovf  <= 1'b0;
    end else begin
      wbin  <= wbin_next;
      wptr  <= wgray_next;
      wfull <= wfull_val;
      if (winc && wfull) begin
        wovf <= 1'b1;
      end else if (wclr_ovf) begin
        wovf <= 1'b0;
      end
    end
  end

`ifdef WPTR_LEVEL_EN
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] level_next;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i < int'(PW); i++) begin
      rbin_s[i] = ^(wq2_rptr >> i);
    end
  end

  // Modulo subtraction gives the occupancy directly, including the full case.
  assign level_next = wbin_next - rbin_s;

  // Fill level and almost-full flag, based on the post-write pointer.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wlevel       <= '0;
      walmost_full <= 1'b0;
    end else begin
      wlevel       <= level_next;
      walmost_full <= (level_next >= PW'(AFULL_THRESH));
    end
  end
`else
  assign wlevel       = '0;
  assign walmost_full = 1'b0;
`endif

endmodule
